serial_subtractor_ctrl: RTL and testbench



---
 rtl/sub_pkg.sv | 12 +
 rtl/Half_Subtractor.sv | 12 +
 rtl/full_sub_cell.sv | 30 +++
 rtl/serial_subtractor_ctrl.sv | 99 +++++++++
 tb/tb_serial_subtractor_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor family.
package sub_pkg;

  localparam int unsigned SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/Half_Subtractor.sv
// Half subtractor: d = x - y, b = borrow out.
module Half_Subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);

  assign d = x ^ y;
  assign b = ~x & y;

endmodule

// File: rtl/full_sub_cell.sv
// Full subtractor built from two half subtractors and an OR of their borrows.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  Half_Subtractor u_hs0 (
    .x (x),
    .y (y),
    .d (d1),
    .b (b1)
  );

  Half_Subtractor u_hs1 (
    .x (d1),
    .y (bin),
    .d (d),
    .b (b2)
  );

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A - B, LSB first, one full-subtractor cell per cycle with a
// registered borrow; start/done handshake.
module serial_subtractor_ctrl
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             B_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sub_state_t       state;
  sub_state_t       state_n;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] a_sh_n;
  logic [WIDTH-1:0] b_sh_n;
  logic [WIDTH-1:0] r_sh_n;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d_bit;
  logic             bout;
  logic             last_bit;

  full_sub_cell u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (bout)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Next state and shifted operand/result values
  always_comb begin
    state_n = state;
    r_sh_n  = r_sh >> 1;
    a_sh_n  = a_sh >> 1;
    b_sh_n  = b_sh >> 1;
    r_sh_n[WIDTH-1] = d_bit;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last_bit) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, handshake flags and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      cnt   <= '0;
      br    <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == RUN);
      done  <= (state_n == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= A;
            b_sh <= B;
            br   <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          r_sh <= r_sh_n;
          a_sh <= a_sh_n;
          b_sh <= b_sh_n;
          br   <= bout;
          cnt  <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign D     = r_sh;
  assign B_out = br;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Randomised bench for serial_subtractor_ctrl against a transaction-level
// model, plus directed corner cases on 8-bit and 1-bit instances.
module tb_serial_subtractor_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] d;
  logic       bo;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] d1;
  logic       bo1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 0;
  bit hold = 0;
  int last_acc = -1;

  int         m_left = 0;
  bit         m_done = 0;
  logic [7:0] m_d = '0;
  bit         m_bo = 0;
  logic [7:0] p_d = '0;
  bit         p_bo = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .done  (done),
    .D     (d),
    .B_out (bo)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .A     (a1),
    .B     (b1),
    .busy  (busy1),
    .done  (done1),
    .D     (d1),
    .B_out (bo1)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Operation-level model: an accepted start yields the result WIDTH edges later
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_left = 0;
      m_done = 0;
      m_d    = '0;
      m_bo   = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        m_d    = p_d;
        m_bo   = p_bo;
      end
    end else if (start) begin
      m_left = 8;
      p_d    = 8'(a - b);
      p_bo   = (a < b);
      if (hold && last_acc >= 0) cmp("start_spacing", 32'(cyc - last_acc), 32'd10);
      last_acc = cyc;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", 32'(busy), 32'(m_left > 0));
      cmp("done", 32'(done), 32'(m_done));
      if (m_left == 0) begin
        cmp("D", 32'(d), 32'(m_d));
        cmp("B_out", 32'(bo), 32'(m_bo));
      end
    end
  end

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] ed, input bit eb);
    int k;
    int nb;
    int i;
    @(negedge clk);
    start = 1'b1;
    a = ta;
    b = tb;
    @(negedge clk);
    k = cyc;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    nb = 0;
    i = 0;
    while (!done && i < 20) begin
      if (busy) nb++;
      i++;
      @(negedge clk);
    end
    cmp("done_seen", 32'(done), 32'd1);
    cmp("latency", 32'(cyc - k), 32'd8);
    cmp("busy_cycles", 32'(nb), 32'd8);
    cmp("lit_D", 32'(d), 32'(ed));
    cmp("lit_B_out", 32'(bo), 32'(eb));
    @(negedge clk);
  endtask

  task automatic op1(input bit ta, input bit tb, input bit ed, input bit eb);
    @(negedge clk);
    start1 = 1'b1;
    a1 = ta;
    b1 = tb;
    @(negedge clk);
    start1 = 1'b0;
    a1 = ~a1;
    b1 = ~b1;
    cmp("w1_busy", 32'(busy1), 32'd1);
    cmp("w1_done_early", 32'(done1), 32'd0);
    @(negedge clk);
    cmp("w1_done", 32'(done1), 32'd1);
    cmp("w1_busy_off", 32'(busy1), 32'd0);
    cmp("w1_D", 32'(d1), 32'(ed));
    cmp("w1_B_out", 32'(bo1), 32'(eb));
    @(negedge clk);
    cmp("w1_done_pulse", 32'(done1), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    start1 = 1'b0;
    a1 = '0;
    b1 = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_done", 32'(done), 32'd0);
    cmp("rst_D", 32'(d), 32'd0);
    cmp("rst_B_out", 32'(bo), 32'd0);
    rst = 1'b0;

    op8(8'd100, 8'd37, 8'd63, 1'b0);
    op8(8'd5, 8'd9, 8'd252, 1'b1);
    op8(8'd0, 8'd255, 8'd1, 1'b1);
    op8(8'd0, 8'd0, 8'd0, 1'b0);
    op8(8'd255, 8'd0, 8'd255, 1'b0);

    // Abort in the middle of an operation
    @(negedge clk);
    start = 1'b1;
    a = 8'd77;
    b = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("abort_busy", 32'(busy), 32'd0);
    cmp("abort_done", 32'(done), 32'd0);
    cmp("abort_D", 32'(d), 32'd0);
    cmp("abort_B_out", 32'(bo), 32'd0);
    repeat (12) @(negedge clk);
    op8(8'd200, 8'd13, 8'd187, 1'b0);

    // start held high while operands keep changing
    last_acc = -1;
    hold = 1;
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      @(negedge clk);
    end
    hold = 0;
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Random traffic with occasional resets
    for (int i = 0; i < 15000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      a = 8'($urandom);
      b = 8'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (12) @(negedge clk);

    op1(1'b1, 1'b0, 1'b1, 1'b0);
    op1(1'b0, 1'b1, 1'b1, 1'b1);
    op1(1'b1, 1'b1, 1'b0, 1'b0);
    op1(1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
